// File: rtl/seq_pattern_detector_pkg.sv
// seq_det_pkg: shared types and constants for the programmable serial pattern detector.
//   state_e   : detector FSM state (ST_IDLE, ST_FILL, ST_ARMED)
//   PAT_W_MIN : smallest supported pattern/window width
//   PAT_W_MAX : largest supported pattern/window width
package seq_det_pkg;

   localparam int unsigned PAT_W_MIN = 2;
   localparam int unsigned PAT_W_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARMED
   } state_e;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector_if: serial bit stream, control and status bundle of the detector.
//   x_valid, x            : qualified serial input bit
//   load, pattern_in,
//   mask_in               : pattern/mask capture strobe and values (bit 0 = newest bit)
//   overlap               : 1 = overlapping matches, 0 = restart window after a match
//   clear                 : empty window and zero the match count
//   out                   : registered one-cycle match pulse
//   hit_cnt               : saturating match count
// Modports: master drives stream/control (bit source, control logic); slave is the detector.
interface seq_pattern_detector_if #(
   parameter int unsigned PAT_W = 3,
   parameter int unsigned CNT_W = 8
) ();

   logic             x_valid;
   logic             x;
   logic             load;
   logic [PAT_W-1:0] pattern_in;
   logic [PAT_W-1:0] mask_in;
   logic             overlap;
   logic             clear;
   logic             out;
   logic [CNT_W-1:0] hit_cnt;

   modport master (
      output x_valid, x, load, pattern_in, mask_in, overlap, clear,
      input  out, hit_cnt
   );

   modport slave (
      input  x_valid, x, load, pattern_in, mask_in, overlap, clear,
      output out, hit_cnt
   );

endinterface

// File: rtl/seq_det_window.sv
// seq_det_window: sliding window shift register plus fill counter.
//   clk, rst_n : clock, synchronous active-low reset
//   accept     : shift x into the window this cycle
//   flush      : empty the window (wins over accept)
//   x          : serial data bit
//   win        : the PAT_W-1 most recent accepted bits, bit 0 newest
//   fill       : number of valid bits in win, saturates at PAT_W-1
module seq_det_window #(
   parameter int unsigned PAT_W  = 3,
   parameter int unsigned FILL_W = $clog2(PAT_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              flush,
   input  logic              x,
   output logic [PAT_W-2:0]  win,
   output logic [FILL_W-1:0] fill
);

   logic [PAT_W-2:0]  win_q, win_d, win_shift;
   logic [FILL_W-1:0] fill_q, fill_d;

   // Only PAT_W-1 bits are stored; the completing bit is compared straight from x.
   if (PAT_W == 2) begin : g_shift_one
      assign win_shift = x;
   end else begin : g_shift_many
      assign win_shift = {win_q[PAT_W-3:0], x};
   end

   always_comb begin
      win_d  = win_q;
      fill_d = fill_q;
      if (flush) begin
         win_d  = '0;
         fill_d = '0;
      end else if (accept) begin
         win_d = win_shift;
         if (fill_q != FILL_W'(PAT_W - 1)) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

   assign win  = win_q;
   assign fill = fill_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable serial pattern detector with don't-care mask.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seq_pattern_detector_if.slave (stream in, load/clear/overlap, out pulse, hit_cnt)
// Optional build macro SEQ_DET_COUNT_EN: when defined the saturating hit_cnt counter is built;
// otherwise hit_cnt is tied to zero. out behaves identically in both builds.
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seq_pattern_detector_if.slave bus
);

   localparam int unsigned FILL_W = $clog2(PAT_W);

   state_e            state_q;
   logic [PAT_W-1:0]  pat_q;
   logic [PAT_W-1:0]  mask_q;
   logic              out_q;
   logic [PAT_W-2:0]  win;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  cand;
   logic              accept;
   logic              match;
   logic              flush;

   // load/clear outrank the data bit: a bit arriving with either strobe is dropped.
   assign accept = bus.x_valid & ~bus.load & ~bus.clear;
   assign cand   = {win, bus.x};
   assign match  = accept && (state_q == ST_ARMED) && (((cand ^ pat_q) & mask_q) == '0);
   assign flush  = bus.load | bus.clear | (match & ~bus.overlap);

   seq_det_window #(
      .PAT_W  (PAT_W),
      .FILL_W (FILL_W)
   ) u_window (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (accept),
      .flush  (flush),
      .x      (bus.x),
      .win    (win),
      .fill   (fill)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '1;
         mask_q  <= '1;
         out_q   <= 1'b0;
      end else begin
         out_q <= match;
         if (bus.load) begin
            pat_q  <= bus.pattern_in;
            mask_q <= bus.mask_in;
         end
         if (bus.load || bus.clear) begin
            state_q <= ST_IDLE;
         end else if (accept) begin
            unique case (state_q)
               ST_IDLE:  state_q <= (PAT_W == 2) ? ST_ARMED : ST_FILL;
               ST_FILL:  if (fill == FILL_W'(PAT_W - 2)) state_q <= ST_ARMED;
               ST_ARMED: if (match && !bus.overlap) state_q <= ST_IDLE;
               default:  state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.out = out_q;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (bus.clear) begin
         cnt_q <= '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.hit_cnt = cnt_q;
`else
   assign bus.hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector (PAT_W=3, CNT_W=2). The driver pushes the
// hand-computed out pulse and a saturating count model into a queue after each edge;
// a monitor on the falling edge pops and compares.
module tb_seq_pattern_detector;

   localparam int unsigned PAT_W = 3;
   localparam int unsigned CNT_W = 2;

   typedef struct {
      int               id;
      logic             o;
      logic [CNT_W-1:0] c;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t exp_q[$];
   exp_t e;
   int   n_cmp;
   int   n_bad;
   int   step_id;
   int   cyc;
   int   drain;
   logic stim_done;
   logic [CNT_W-1:0] mcnt;

   seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   seq_pattern_detector #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; eo is the expected out after this edge.
   task automatic step(input logic rn, input logic v, input logic xb, input logic ld,
                       input logic cl, input logic eo);
      exp_t t;
      rst_n       = rn;
      bus.x_valid = v;
      bus.x       = xb;
      bus.load    = ld;
      bus.clear   = cl;
      @(posedge clk);
      #1;
      if (!rn || cl) mcnt = '0;
      else if (eo && (mcnt != '1)) mcnt = mcnt + 1'b1;
      t.id = step_id;
      t.o  = eo;
`ifdef SEQ_DET_COUNT_EN
      t.c  = mcnt;
`else
      t.c  = '0;
`endif
      exp_q.push_back(t);
      step_id++;
   endtask

   task automatic load_pat(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
      bus.pattern_in = p;
      bus.mask_in    = m;
      step(1, 0, 0, 1, 0, 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; step_id = 0; cyc = 0; drain = 0;
      stim_done = 1'b0;
      mcnt = '0;
      bus.pattern_in = 3'b111;
      bus.mask_in    = 3'b111;
      bus.overlap    = 1'b1;

      // Reset: out=0, hit_cnt=0, default 111 pattern.
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Default 111, overlap: 1,1,1,1,0 -> pulses after 3rd and 4th.
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);

      // No overlap: six 1s -> pulses after 3rd and 6th.
      bus.overlap = 1'b0;
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      // clear with a valid bit: bit dropped.
      step(1, 1, 1, 0, 1, 0);

      // Pattern 101 mask 111, overlap: 1,0,1,0,1 -> two hits.
      bus.overlap = 1'b1;
      load_pat(3'b101, 3'b111);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      // clear keeps pattern 101; no overlap -> one hit.
      step(1, 0, 0, 0, 1, 0);
      bus.overlap = 1'b0;
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);

      // Mask 101 pattern 101: 1,1,1 matches, 1,0,0 does not.
      bus.overlap = 1'b1;
      load_pat(3'b101, 3'b101);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      load_pat(3'b101, 3'b101);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);

      // load with a valid bit drops the bit; then 1, 4-cycle gap, 1,1 -> one hit.
      bus.pattern_in = 3'b111;
      bus.mask_in    = 3'b111;
      step(1, 1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0);

      // Reset mid-stream loses the partial window.
      step(1, 0, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);

      // Saturation: four back-to-back overlapping hits on a 2-bit counter.
      step(1, 0, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);

      // All-zero mask: every armed bit matches, with and without overlap.
      load_pat(3'b010, 3'b000);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0, 1);
      bus.overlap = 1'b0;
      step(1, 1, 1, 0, 0, 1);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 1, 0);

      stim_done = 1'b1;
   end

   // Monitor: sole owner of the counters; also ends the run.
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.out !== e.o) begin
            n_bad++;
            $display("FAIL out step %0d: got %b want %b", e.id, bus.out, e.o);
         end
         n_cmp++;
         if (bus.hit_cnt !== e.c) begin
            n_bad++;
            $display("FAIL hit_cnt step %0d: got %0d want %0d", e.id, bus.hit_cnt, e.c);
         end
      end
      if (stim_done) drain++;
      if (stim_done && exp_q.size() == 0) begin
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end else if (drain > 10 || cyc > 5000) begin
         n_bad++;
         $display("FAIL timeout: cycle %0d, %0d expectations pending", cyc, exp_q.size());
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

endmodule
